// File: rtl/serial_add_sequencer.sv
`default_nettype none
// =====================================================================================
// serial_add_sequencer: valid/ready operand buffer, load/wait/capture FSM for the
// bit-serial adder. SEQ_FIFO_EN selects a DEPTH-entry FIFO over a single register.
// Rev 1.0
// =====================================================================================
module serial_add_sequencer #(
  parameter int N           = 4,
  parameter int DEPTH       = 4,
  parameter int WAIT_CYCLES = 2*N+6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_load,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          buf_empty;
  logic          push;
  logic          pop;
  logic [N-1:0]  head_a;
  logic [N-1:0]  head_b;

  assign push = in_valid && in_ready;
  assign pop  = (state == S_IDLE) && !buf_empty;

`ifdef SEQ_FIFO_EN
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = AW + 1;

  logic [N-1:0]    mem_a [DEPTH];
  logic [N-1:0]    mem_b [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;

  assign buf_empty = (count == '0);
  assign in_ready  = (count != CNTW'(DEPTH));
  assign head_a    = mem_a[rd_ptr];
  assign head_b    = mem_b[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_a[wr_ptr] <= in_a;
        mem_b[wr_ptr] <= in_b;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: ;
      endcase
    end
  end
`else
  logic         hold_valid;
  logic [N-1:0] hold_a;
  logic [N-1:0] hold_b;

  // An occupied register in IDLE is popped on this edge, so it can take a new pair too.
  assign in_ready  = !hold_valid || (state == S_IDLE);
  assign buf_empty = !hold_valid;
  assign head_a    = hold_a;
  assign head_b    = hold_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_a     <= '0;
      hold_b     <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_a     <= in_a;
      hold_b     <= in_b;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_load  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            add_a    <= head_a;
            add_b    <= head_b;
            add_load <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          add_load <= 1'b0;
          cnt      <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == LAST) state <= S_CAPTURE;
          else             cnt   <= cnt + CW'(1);
        end
        S_CAPTURE: begin
          out_sum   <= add_sum;
          out_cout  <= add_cout;
          out_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
`default_nettype none
// tb_serial_add_sequencer: random and directed stimulus against a queue-based
// scoreboard plus a behavioural bit-serial adder with a fixed compute delay.
module tb_serial_add_sequencer;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int WAITC = 14;
  localparam int LAT   = 16;
`ifdef SEQ_FIFO_EN
  localparam int CAP = DEPTH + 1;
`else
  localparam int CAP = 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_load;
  logic [N-1:0] add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_sum;
  logic         out_cout;

  serial_add_sequencer #(.N(N), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_load(add_load),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Adder stand-in: shows a wrong value until WAITC cycles after its load edge.
  logic [N-1:0] m_a;
  logic [N-1:0] m_b;
  int           m_cnt;
  logic [N:0]   m_sum;
  assign m_sum = {1'b0, m_a} + {1'b0, m_b};
  assign {add_cout, add_sum} = (m_cnt == 0) ? m_sum : ~m_sum;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= '0; m_b <= '0; m_cnt <= 0;
    end else if (add_load) begin
      m_a <= add_a; m_b <= add_b; m_cnt <= WAITC;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  // out_ready policy: 0 = low, 1 = high, 2 = random
  int ready_mode = 1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard, sampled on the falling edge.
  logic [2*N-1:0] pend_q[$];
  int   cyc = 0, load_cyc = 0, acc_cnt = 0, res_cnt = 0, load_cnt = 0;
  bit   in_flight = 0, prev_valid = 0, prev_load = 0, prev_acc = 0;
  logic [N-1:0] iss_a, iss_b, held_sum;
  logic         held_cout;

  always @(negedge clk) begin
    int s;
    logic [2*N-1:0] item;
    cyc++;
    if (rst) begin
      pend_q.delete();
      acc_cnt    = res_cnt;
      in_flight  = 0;
      prev_valid = 0;
      prev_load  = 0;
      prev_acc   = 0;
    end else begin
      if (add_load) begin
        load_cnt++;
        check("load_while_busy", 32'(in_flight), 0);
        check("load_width", 32'(prev_load), 0);
        if (pend_q.size() == 0) begin
          check("load_without_pair", 1, 0);
        end else begin
          item = pend_q.pop_front();
          check("add_a_at_load", 32'(add_a), 32'(item[2*N-1:N]));
          check("add_b_at_load", 32'(add_b), 32'(item[N-1:0]));
          iss_a = item[2*N-1:N];
          iss_b = item[N-1:0];
        end
        in_flight = 1;
        load_cyc  = cyc;
      end else if (in_flight) begin
        check("add_a_stable", 32'(add_a), 32'(iss_a));
        check("add_b_stable", 32'(add_b), 32'(iss_b));
      end
      if (prev_acc) check("valid_drop", 32'(out_valid), 0);
      if (out_valid && !prev_valid) begin
        check("result_expected", 32'(in_flight), 1);
        check("latency", 32'(cyc - load_cyc), LAT);
        s = int'(iss_a) + int'(iss_b);
        check("out_sum", 32'(out_sum), 32'(s % 16));
        check("out_cout", 32'(out_cout), 32'(s / 16));
        held_sum  = out_sum;
        held_cout = out_cout;
        res_cnt++;
      end else if (out_valid) begin
        check("sum_stable", 32'(out_sum), 32'(held_sum));
        check("cout_stable", 32'(out_cout), 32'(held_cout));
      end
      prev_acc = out_valid && out_ready;
      if (prev_acc) in_flight = 0;
      if (in_valid && in_ready) begin
        pend_q.push_back({in_a, in_b});
        acc_cnt++;
      end
      prev_valid = out_valid;
      prev_load  = add_load;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
    bit done = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && res_cnt != acc_cnt; k++) tick();
    check("drain", 32'(res_cnt), 32'(acc_cnt));
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_add_a", 32'(add_a), 0);
    check("rst_add_b", 32'(add_b), 0);
    check("rst_add_load", 32'(add_load), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sum", 32'(out_sum), 0);
    check("rst_out_cout", 32'(out_cout), 0);
  endtask

  initial begin
    int snap, bound;
    check_reset_outputs();
    tick();
    rst = 1'b0;
    tick();

    // single add
    push(4'd5, 4'd3);
    wait_drain(100);

    // carry cases in order
    push(4'd15, 4'd1);
    push(4'd9, 4'd9);
    wait_drain(200);

    // result back-pressure holds the output and stalls issue
    ready_mode = 0;
    push(4'd2, 4'd3);
    bound = 0;
    while (!out_valid && bound < 100) begin tick(); bound++; end
    check("first_result_seen", 32'(out_valid), 1);
    snap = load_cnt;
    push(4'd4, 4'd4);
    repeat (40) tick();
    check("no_load_while_held", 32'(load_cnt), 32'(snap));
    ready_mode = 1;
    wait_drain(200);

    // capacity: one in flight plus the buffer
    ready_mode = 0;
    tick();
    snap = acc_cnt;
    in_valid = 1'b1;
    repeat (60) begin
      in_a = 4'($urandom);
      in_b = 4'($urandom);
      tick();
    end
    in_valid = 1'b0;
    check("accepted_when_stalled", 32'(acc_cnt - snap), 32'(CAP));
    @(negedge clk);
    check("in_ready_full", 32'(in_ready), 0);
    tick();
    ready_mode = 1;
    wait_drain(800);
    repeat (3) tick();
    @(negedge clk);
    check("in_ready_restored", 32'(in_ready), 1);
    tick();

    // back-to-back pushes: second lands on the pop edge of the first
    in_valid = 1'b1; in_a = 4'd6; in_b = 4'd12;
    @(negedge clk);
    check("b2b_first_ready", 32'(in_ready), 1);
    tick();
    in_a = 4'd11; in_b = 4'd13;
    @(negedge clk);
    check("push_on_pop_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    wait_drain(200);

    // reset in the middle of WAIT
    snap = load_cnt;
    push(4'd7, 4'd6);
    bound = 0;
    while (load_cnt == snap && bound < 50) begin tick(); bound++; end
    check("rst_pair_loaded", 32'(load_cnt), 32'(snap + 1));
    repeat (5) tick();
    rst = 1'b1;
    check_reset_outputs();
    tick();
    rst = 1'b0;
    snap = res_cnt;
    repeat (30) tick();
    check("no_result_after_rst", 32'(res_cnt), 32'(snap));
    push(4'd1, 4'd2);
    wait_drain(100);

    // random traffic with random back-pressure
    ready_mode = 2;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      push(4'($urandom), 4'($urandom));
    end
    ready_mode = 1;
    wait_drain(2000);
    repeat (3) tick();
    check("queue_empty", 32'(pend_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
